uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and bit-timing helper, reused by rx and tx.
package uart_pkg;

  localparam logic [2:0] STATE_IDLE      = 3'd0;
  localparam logic [2:0] STATE_START     = 3'd1;
  localparam logic [2:0] STATE_DATA      = 3'd2;
  localparam logic [2:0] STATE_STOP      = 3'd3;
  localparam logic [2:0] STATE_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = STATE_IDLE,
    ST_START     = STATE_START,
    ST_DATA      = STATE_DATA,
    ST_STOP      = STATE_STOP,
    ST_WAIT_HIGH = STATE_WAIT_HIGH
  } uart_state_e;

  // Whole system clocks per serial bit; the fractional part is dropped.
  function automatic int calc_clks_per_bit(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter int   DEPTH       = 2,    // must be at least 2
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the raw input through the flop chain; the last stage is the safe copy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= {DEPTH{RESET_VALUE}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling, valid/ready output with overrun detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int NUM_BITS      = 8       // must be at least 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                framing_error,
  output logic                overrun_error
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam int CNT_W        = $clog2(NUM_BITS + 1);

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(NUM_BITS - 1);

  logic                rx_sync;
  uart_state_e         state, state_next;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_next;
  logic [NUM_BITS-1:0] shreg, shreg_next;
  logic                deliver;
  logic                frame_err_next;
  logic                accept;

  uart_sync #(
    .DEPTH       (2),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  // Frame-tracking registers: state, bit timer, bit counter, shift register, framing pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      bit_cnt       <= bit_cnt_next;
      shreg         <= shreg_next;
      framing_error <= frame_err_next;
    end
  end

  // Next-state and datapath decisions, all taken on the synchronized line value.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next     = state;
    timer_next     = timer;
    bit_cnt_next   = bit_cnt;
    shreg_next     = shreg;
    deliver        = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_next = '0;
        if (!rx_sync) state_next = ST_START;
      end

      ST_START: begin
        if (timer == HALF_LAST) begin
          timer_next   = '0;
          bit_cnt_next = '0;
          // A line that is high again by mid start bit was only a glitch.
          state_next   = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_DATA: begin
        if (timer == BIT_LAST) begin
          timer_next   = '0;
          // LSB arrives first, so each new bit enters at the top and shifts down.
          shreg_next   = {rx_sync, shreg[NUM_BITS-1:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) state_next = ST_STOP;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_STOP: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (rx_sync) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_WAIT_HIGH;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_WAIT_HIGH: begin
        timer_next = '0;
        if (rx_sync) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = rx_data_valid && rx_data_ready;

  // Output holding register: load on delivery if free or being drained, else flag overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (deliver) begin
        if (!rx_data_valid || accept) begin
          rx_data       <= shreg;
          rx_data_valid <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (accept) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a line-level model.
module tb_uart_rx;

  // A reduced clock keeps the 256-frame sweep short; bit timing scales with CPB.
  localparam int CLK_HZ = 1_843_200;
  localparam int BAUD   = 115_200;
  localparam int NB     = 8;
  localparam int CPB    = CLK_HZ / BAUD;   // 16 clocks per bit
  localparam int FRAME  = (NB + 2) * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [NB-1:0] rx_data;
  logic          rx_data_valid;
  logic          rx_data_ready;
  logic          framing_error;
  logic          overrun_error;

  int errors = 0;
  int checks = 0;

  // Monitor totals, only ever written by the monitor.
  int            valid_cycles = 0;
  int            fe_cnt       = 0;
  int            oe_cnt       = 0;
  logic [NB-1:0] rx_q[$];

  uart_rx #(
    .CLOCK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE     (BAUD),
    .NUM_BITS      (NB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  // Sample outputs mid-cycle; a word counts as received when valid and ready meet.
  always @(negedge clk) begin
    if (rx_data_valid) valid_cycles <= valid_cycles + 1;
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (overrun_error) oe_cnt <= oe_cnt + 1;
    if (rx_data_valid && rx_data_ready) rx_q.push_back(rx_data);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(CPB);
  endtask

  // Line-level frame: start 0, data LSB first, then the chosen stop level.
  task automatic send_frame(input logic [NB-1:0] d, input logic stop_bit);
    logic [NB+1:0] line;
    line = {stop_bit, d, 1'b0};
    for (int i = 0; i < NB + 2; i++) send_bit(line[i]);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    step(n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    rx_data_ready = 1'b0;
    step(4);
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h, expected 0", rx_data); end
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, expected 0", rx_data_valid); end
    checks++;
    if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %0b, expected 0", framing_error); end
    checks++;
    if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_oe: got %0b, expected 0", overrun_error); end
    checks++;
    reset = 1'b0;
    step(CPB);
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %0b, expected 0", rx_data_valid); end
    checks++;
  endtask

  // Expect exactly one new word equal to exp since the snapshot q0.
  task automatic expect_word(input string name, input int q0, input logic [NB-1:0] exp);
    if (rx_q.size() - q0 !== 1) begin errors++; $display("FAIL %s_count: got %0d words, expected 1", name, rx_q.size() - q0); end
    checks++;
    if (rx_q.size() > q0) begin
      if (rx_q[q0] !== exp) begin errors++; $display("FAIL %s_data: got %0h, expected %0h", name, rx_q[q0], exp); end
      checks++;
    end
  endtask

  task automatic test_single;
    int v0, f0, o0, q0;
    rx_data_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; o0 = oe_cnt; q0 = rx_q.size();
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    expect_word("single", q0, 8'hA5);
    if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL single_valid_len: got %0d cycles, expected 1", valid_cycles - v0); end
    checks++;
    if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL single_fe: got %0d, expected 0", fe_cnt - f0); end
    checks++;
    if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL single_oe: got %0d, expected 0", oe_cnt - o0); end
    checks++;
  endtask

  task automatic test_glitch;
    int v0, f0, q0;
    rx_data_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; q0 = rx_q.size();
    rx = 1'b0;
    step(CPB / 4);
    idle(2 * CPB);
    if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d cycles, expected 0", valid_cycles - v0); end
    checks++;
    if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_fe: got %0d, expected 0", fe_cnt - f0); end
    checks++;
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    expect_word("after_glitch", q0, 8'h5A);
  endtask

  task automatic test_framing;
    int v0, f0, o0, q0;
    rx_data_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; o0 = oe_cnt; q0 = rx_q.size();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    step(3 * FRAME);
    idle(2 * CPB);
    if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL framing_fe: got %0d, expected 1", fe_cnt - f0); end
    checks++;
    if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL framing_valid: got %0d cycles, expected 0", valid_cycles - v0); end
    checks++;
    if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL framing_oe: got %0d, expected 0", oe_cnt - o0); end
    checks++;
    send_frame(8'h7E, 1'b1);
    idle(2 * CPB);
    expect_word("after_framing", q0, 8'h7E);
    if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL framing_fe_total: got %0d, expected 1", fe_cnt - f0); end
    checks++;
  endtask

  task automatic test_overrun;
    int f0, o0, q0;
    rx_data_ready = 1'b0;
    f0 = fe_cnt; o0 = oe_cnt; q0 = rx_q.size();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2 * CPB);
    if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %0b, expected 1", rx_data_valid); end
    checks++;
    if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_held: got %0h, expected 11", rx_data); end
    checks++;
    if (oe_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_oe: got %0d, expected 1", oe_cnt - o0); end
    checks++;
    if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL overrun_fe: got %0d, expected 0", fe_cnt - f0); end
    checks++;
    rx_data_ready = 1'b1;
    step(1);
    rx_data_ready = 1'b0;
    step(1);
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: got %0b, expected 0", rx_data_valid); end
    checks++;
    expect_word("overrun_accept", q0, 8'h11);
    rx_data_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, o0, q0;
    logic [NB-1:0] d;
    rx_data_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; o0 = oe_cnt; q0 = rx_q.size();
    d = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    step(CPB / 2);
    reset = 1'b1;
    rx = 1'b1;
    step(3);
    reset = 1'b0;
    idle(2 * FRAME);
    if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL midreset_valid: got %0d cycles, expected 0", valid_cycles - v0); end
    checks++;
    if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL midreset_fe: got %0d, expected 0", fe_cnt - f0); end
    checks++;
    if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL midreset_oe: got %0d, expected 0", oe_cnt - o0); end
    checks++;
    send_frame(8'h0F, 1'b1);
    idle(2 * CPB);
    expect_word("after_midreset", q0, 8'h0F);
  endtask

  task automatic test_back_to_back;
    int f0, o0, q0, bad;
    rx_data_ready = 1'b1;
    f0 = fe_cnt; o0 = oe_cnt; q0 = rx_q.size();
    for (int v = 0; v < 256; v++) send_frame(NB'(v), 1'b1);
    idle(2 * CPB);
    if (rx_q.size() - q0 !== 256) begin errors++; $display("FAIL b2b_count: got %0d words, expected 256", rx_q.size() - q0); end
    checks++;
    bad = 0;
    for (int v = 0; v < 256 && q0 + v < rx_q.size(); v++) begin
      if (rx_q[q0 + v] !== NB'(v)) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL b2b_word_%0d: got %0h, expected %0h", v, rx_q[q0 + v], v);
      end
      checks++;
    end
    if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_fe: got %0d, expected 0", fe_cnt - f0); end
    checks++;
    if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_oe: got %0d, expected 0", oe_cnt - o0); end
    checks++;
  endtask

  // Random words, gaps and stop levels; the model keeps a word per good stop and a fault per bad one.
  task automatic test_random;
    int f0, o0, q0, exp_fe;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] d;
    logic          stop_bit;
    rx_data_ready = 1'b1;
    f0 = fe_cnt; o0 = oe_cnt; q0 = rx_q.size();
    exp_fe = 0;
    for (int n = 0; n < 24; n++) begin
      d = NB'($urandom);
      stop_bit = ($urandom_range(3) != 0);
      send_frame(d, stop_bit);
      if (stop_bit) begin
        exp_q.push_back(d);
        idle($urandom_range(CPB));
      end else begin
        exp_fe++;
        idle(CPB + $urandom_range(CPB));
      end
    end
    idle(2 * CPB);
    if (rx_q.size() - q0 !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d words, expected %0d", rx_q.size() - q0, exp_q.size());
    end
    checks++;
    for (int i = 0; i < exp_q.size() && q0 + i < rx_q.size(); i++) begin
      if (rx_q[q0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word_%0d: got %0h, expected %0h", i, rx_q[q0 + i], exp_q[i]);
      end
      checks++;
    end
    if (fe_cnt - f0 !== exp_fe) begin errors++; $display("FAIL rand_fe: got %0d, expected %0d", fe_cnt - f0, exp_fe); end
    checks++;
    if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL rand_oe: got %0d, expected 0", oe_cnt - o0); end
    checks++;
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_data_ready = 1'b0;
    test_reset;
    test_single;
    test_glitch;
    test_framing;
    test_overrun;
    test_reset_mid_frame;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
